// File: rtl/dec_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface dec_stage_if #(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [REG_ID_W-1:0] rd;
    logic [REG_ID_W-1:0] rs1;
    logic [REG_ID_W-1:0] rs2;
    logic [XLEN-1:0]     imm;
    logic [3:0]          alu_op;
    logic [3:0]          inst_type;
    logic [3:0]          mem_wbmask;
    logic [1:0]          mem_size;
    logic                is_mem_sign;
    logic                illegal;
    logic                halted;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op,
               inst_type, mem_wbmask, mem_size, is_mem_sign, illegal, halted
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op,
               inst_type, mem_wbmask, mem_size, is_mem_sign, illegal, halted
    );
endinterface

// File: rtl/dec_stage.sv
// Registered RV32I/RV32E decode stage with valid/ready handshake and an ECALL/EBREAK halt FSM.
// Optional macro DEC_SKID_EN adds a one-entry skid buffer and makes in_ready a register.
module dec_stage #(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 5
) (
    input logic        clock,
    input logic        reset,
    dec_stage_if.slave io
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_FENCE = 7'b0001111, OP_ENV = 7'b1110011;
    localparam logic [3:0] T_NONE = 4'd0, T_REG = 4'd1, T_IMM = 4'd2, T_LUI = 4'd3,
                           T_AUIPC = 4'd4, T_JAL = 4'd5, T_JALR = 4'd6, T_BR = 4'd7,
                           T_STORE = 4'd11, T_ENV = 4'd12, T_FENCE = 4'd13;
    // Shift immediates: everything above the shamt must be zero, or the SRA marker alone.
    localparam int SHW = (XLEN == 64) ? 6 : 5;
    localparam logic [11-SHW:0] SRA_HI = {1'b0, 1'b1, {(10-SHW){1'b0}}};

    typedef enum logic [1:0] {RUN, HALT_PEND, HALT} state_e;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [REG_ID_W-1:0] rd;
        logic [REG_ID_W-1:0] rs1;
        logic [REG_ID_W-1:0] rs2;
        logic [XLEN-1:0]     imm;
        logic [3:0]          alu_op;
        logic [3:0]          itype;
        logic [3:0]          wbmask;
        logic [1:0]          msize;
        logic                msign;
        logic                illegal;
    } bundle_t;

    logic [31:0]     inst;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [11-SHW:0] sh_hi;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            use_rd, use_rs1, use_rs2, bad;
    bundle_t         dec;

    assign inst  = io.in_inst;
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign sh_hi = inst[31:20+SHW];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // Full 7-bit opcode match, so inst[1:0] != 11 falls into the unknown-opcode path.
    always_comb begin
        dec     = '0;
        dec.pc  = io.in_pc;
        dec.rd  = inst[7 +: REG_ID_W];
        dec.rs1 = inst[15 +: REG_ID_W];
        dec.rs2 = inst[20 +: REG_ID_W];
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        case (inst[6:0])
            OP_REG: begin
                dec.itype  = T_REG;
                dec.alu_op = {inst[30], f3};
                {use_rd, use_rs1, use_rs2} = 3'b111;
                bad = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_IMM: begin
                dec.itype  = T_IMM;
                dec.imm    = imm_i;
                dec.alu_op = {inst[30] & (f3 == 3'b101), f3};
                {use_rd, use_rs1} = 2'b11;
                if (f3 == 3'b001)      bad = (sh_hi != '0);
                else if (f3 == 3'b101) bad = (sh_hi != '0) && (sh_hi != SRA_HI);
            end
            OP_LUI:   begin dec.itype = T_LUI;   dec.imm = imm_u; use_rd = 1'b1; end
            OP_AUIPC: begin dec.itype = T_AUIPC; dec.imm = imm_u; use_rd = 1'b1; end
            OP_JAL:   begin dec.itype = T_JAL;   dec.imm = imm_j; use_rd = 1'b1; end
            OP_JALR: begin
                dec.itype = T_JALR;
                dec.imm   = imm_i;
                {use_rd, use_rs1} = 2'b11;
                bad = (f3 != 3'b000);
            end
            OP_BR: begin
                dec.itype  = T_BR;
                dec.imm    = imm_b;
                dec.alu_op = {1'b0, f3};
                {use_rs1, use_rs2} = 2'b11;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                dec.itype = {2'b10, f3[1:0]};
                dec.imm   = imm_i;
                dec.msize = f3[1:0];
                dec.msign = !f3[2];
                {use_rd, use_rs1} = 2'b11;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.itype = T_STORE;
                dec.imm   = imm_s;
                dec.msize = f3[1:0];
                dec.msign = !f3[2];
                case (f3[1:0])
                    2'b00:   dec.wbmask = 4'b0001;
                    2'b01:   dec.wbmask = 4'b0011;
                    default: dec.wbmask = 4'b1111;
                endcase
                {use_rs1, use_rs2} = 2'b11;
                bad = f3[2] || (f3[1:0] == 2'b11);
            end
            OP_FENCE: dec.itype = T_FENCE;
            OP_ENV:   dec.itype = T_ENV;
            default:  bad = 1'b1;
        endcase
        if (REG_ID_W == 4 && ((use_rd & inst[11]) | (use_rs1 & inst[19]) | (use_rs2 & inst[24])))
            bad = 1'b1;
        if (bad) begin
            dec.itype   = T_NONE;
            dec.imm     = '0;
            dec.alu_op  = '0;
            dec.wbmask  = '0;
            dec.msize   = '0;
            dec.msign   = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    state_e  state_q, state_d;
    bundle_t out_q, out_d;
    logic    out_vld_q, out_vld_d;
    logic    accept, out_fire, skid_busy;

    assign accept   = io.in_valid & io.in_ready;
    assign out_fire = out_vld_q & io.out_ready;

`ifdef DEC_SKID_EN
    bundle_t skid_q, skid_d;
    logic    skid_full_q, skid_full_d, in_rdy_q, in_rdy_d;

    assign io.in_ready = in_rdy_q;
    assign skid_busy   = skid_full_q;

    // in_ready is only high with an empty skid, so the skid never overflows.
    always_comb begin
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (!out_vld_q || io.out_ready) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_vld_d   = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
        in_rdy_d = !skid_full_d && (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            in_rdy_q    <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            in_rdy_q    <= in_rdy_d;
        end
    end
`else
    assign io.in_ready = (io.out_ready | !out_vld_q) & (state_q == RUN);
    assign skid_busy   = 1'b0;

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (accept) begin
            out_d     = dec;
            out_vld_d = 1'b1;
        end else if (io.out_ready) begin
            out_vld_d = 1'b0;
        end
    end
`endif

    // Input is closed once an ENV is taken; HALT follows when that ENV leaves the stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (accept && dec.itype == T_ENV) state_d = HALT_PEND;
            HALT_PEND: if (out_fire && !skid_busy) state_d = HALT;
            default:   state_d = HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= RUN;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign io.out_valid   = out_vld_q;
    assign io.out_pc      = out_q.pc;
    assign io.rd          = out_q.rd;
    assign io.rs1         = out_q.rs1;
    assign io.rs2         = out_q.rs2;
    assign io.imm         = out_q.imm;
    assign io.alu_op      = out_q.alu_op;
    assign io.inst_type   = out_q.itype;
    assign io.mem_wbmask  = out_q.wbmask;
    assign io.mem_size    = out_q.msize;
    assign io.is_mem_sign = out_q.msign;
    assign io.illegal     = out_q.illegal;
    assign io.halted      = (state_q == HALT);
endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: a per-cycle scoreboard against a decode model plus literal spot checks.
module tb_dec_stage;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dec_stage_if #(.XLEN(32), .REG_ID_W(5)) d_if ();
    dec_stage_if #(.XLEN(32), .REG_ID_W(4)) e_if ();

    dec_stage #(.XLEN(32), .REG_ID_W(5)) u_dut   (.clock(clock), .reset(reset), .io(d_if));
    dec_stage #(.XLEN(32), .REG_ID_W(4)) u_dut_e (.clock(clock), .reset(reset), .io(e_if));

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  alu, ty, wb;
        logic [1:0]  sz;
        logic        sg, ill;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_pass = 0, n_tot = 0, pops = 0;
    bit          pend = 0, halt_m = 0, rst_prev = 0;
    logic [31:0] pc_c = 32'h1000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Decode from the ISA tables; immediates built arithmetically from a signed view of the word.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input int rw);
        exp_t e;
        logic signed [31:0] si;
        logic [31:0] sgn, ii, ss, bb, uu, jj, t;
        int f3, f7;
        bit ok, urd, urs1, urs2;
        si = i;
        sgn = si >>> 31;
        ii = si >>> 20;
        t = si >>> 25;
        ss = (t << 5) | i[11:7];
        bb = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        uu = i & 32'hFFFFF000;
        jj = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        f3 = i[14:12];
        f7 = i[31:25];
        e = '{pc: pc, imm: 0, rd: i[11:7], rs1: i[19:15], rs2: i[24:20],
              alu: 0, ty: 0, wb: 0, sz: 0, sg: 0, ill: 0};
        ok = 1; urd = 0; urs1 = 0; urs2 = 0;
        case (i[6:0])
            7'h33: begin e.ty = 1; e.alu = {i[30], i[14:12]}; urd = 1; urs1 = 1; urs2 = 1;
                         ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
            7'h13: begin e.ty = 2; e.imm = ii; e.alu = {i[30] & (f3 == 5), i[14:12]}; urd = 1; urs1 = 1;
                         if (f3 == 1) ok = (f7 == 0);
                         if (f3 == 5) ok = (f7 == 0) || (f7 == 32); end
            7'h37: begin e.ty = 3; e.imm = uu; urd = 1; end
            7'h17: begin e.ty = 4; e.imm = uu; urd = 1; end
            7'h6F: begin e.ty = 5; e.imm = jj; urd = 1; end
            7'h67: begin e.ty = 6; e.imm = ii; ok = (f3 == 0); urd = 1; urs1 = 1; end
            7'h63: begin e.ty = 7; e.imm = bb; e.alu = {1'b0, i[14:12]}; ok = (f3 != 2 && f3 != 3);
                         urs1 = 1; urs2 = 1; end
            7'h03: begin e.ty = 4'(8 + f3 % 4); e.imm = ii; e.sz = 2'(f3 % 4); e.sg = (f3 < 4);
                         ok = !(f3 == 3 || f3 == 6 || f3 == 7); urd = 1; urs1 = 1; end
            7'h23: begin e.ty = 11; e.imm = ss; e.wb = 4'((1 << (1 << (f3 % 4))) - 1);
                         e.sz = 2'(f3 % 4); e.sg = (f3 < 4); ok = (f3 < 3); urs1 = 1; urs2 = 1; end
            7'h0F: e.ty = 13;
            7'h73: e.ty = 12;
            default: ok = 0;
        endcase
        if (rw == 4 && ((urd && i[11]) || (urs1 && i[19]) || (urs2 && i[24]))) ok = 0;
        if (!ok) begin
            e.ty = 0; e.wb = 0; e.alu = 0; e.imm = 0; e.sz = 0; e.sg = 0; e.ill = 1;
        end
        return e;
    endfunction

    // Scoreboard: inputs are stable between #1-after-edge and the next edge, so negedge sees the handshake.
    always @(negedge clock) begin
        if (!reset) begin
            q.delete();
            pend = 0; halt_m = 0; rst_prev = 1;
        end else begin
            if (rst_prev) begin
                chk("rst_ctl", {d_if.out_valid, d_if.illegal, d_if.halted, d_if.inst_type,
                                d_if.mem_wbmask, d_if.mem_size, d_if.is_mem_sign, d_if.alu_op}, 0);
                chk("rst_fields", {d_if.out_pc, d_if.imm}, 0);
                chk("rst_ids", {d_if.rd, d_if.rs1, d_if.rs2}, 0);
                rst_prev = 0;
            end
            chk("halted", d_if.halted, halt_m);
            chk("in_ready", d_if.in_ready, (d_if.out_ready || q.size() == 0) && !pend && !halt_m);
            chk("out_valid", d_if.out_valid, q.size() != 0);
            if (d_if.out_valid && q.size() != 0) begin
                cur = q[0];
                chk("out_pc", d_if.out_pc, cur.pc);
                chk("imm", d_if.imm, cur.imm);
                chk("regs", {d_if.rd, d_if.rs1, d_if.rs2}, {cur.rd, cur.rs1, cur.rs2});
                chk("alu_op", d_if.alu_op, cur.alu);
                chk("inst_type", d_if.inst_type, cur.ty);
                chk("mem", {d_if.mem_wbmask, d_if.mem_size, d_if.is_mem_sign},
                    {cur.wb, cur.sz, cur.sg});
                chk("illegal", d_if.illegal, cur.ill);
                if (d_if.out_ready) begin
                    cur = q.pop_front();
                    pops++;
                    if (cur.ty == 12) begin pend = 0; halt_m = 1; end
                end
            end
            if (d_if.in_valid && d_if.in_ready) begin
                cur = model(d_if.in_inst, d_if.in_pc, 5);
                q.push_back(cur);
                if (cur.ty == 12) pend = 1;
            end
        end
    end

    // Holds the word until accepted; returns #1 after the accepting edge with in_valid dropped.
    task automatic push(input logic [31:0] inst);
        int  n = 0;
        bit  acc = 0;
        d_if.in_valid = 1'b1;
        d_if.in_inst  = inst;
        d_if.in_pc    = pc_c;
        do begin
            @(negedge clock);
            acc = d_if.in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_timeout", 0, 1);
        pc_c += 4;
        d_if.in_valid = 1'b0;
    endtask

    task automatic push_e(input logic [31:0] inst);
        e_if.in_valid = 1'b1;
        e_if.in_inst  = inst;
        e_if.in_pc    = 32'h2000;
        @(posedge clock);
        #1;
        e_if.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        int p0;
        d_if.in_valid = 0; d_if.in_inst = 0; d_if.in_pc = 0; d_if.out_ready = 1;
        e_if.in_valid = 0; e_if.in_inst = 0; e_if.in_pc = 0; e_if.out_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("lit_rst", {d_if.out_valid, d_if.illegal, d_if.halted, d_if.imm}, 0);
        reset = 1;

        // addi x1,x0,5
        push(32'h00500093);
        chk("lit_addi", {d_if.out_valid, d_if.inst_type, d_if.rd, d_if.rs1, d_if.imm, d_if.alu_op, d_if.illegal},
            {1'b1, 4'd2, 5'd1, 5'd0, 32'd5, 4'd0, 1'b0});
        push(32'hFE000EE3);
        chk("lit_beq", {d_if.inst_type, d_if.imm}, {4'd7, 32'hFFFFFFFC});
        push(32'h0080006F);
        chk("lit_jal", {d_if.inst_type, d_if.imm}, {4'd5, 32'd8});
        push(32'h00001097);
        chk("lit_auipc", {d_if.inst_type, d_if.rd, d_if.imm}, {4'd4, 5'd1, 32'h1000});

        // illegal and assorted legal/illegal encodings, scored by the model
        push(32'h00003003);
        chk("lit_ld", {d_if.illegal, d_if.inst_type}, {1'b1, 4'd0});
        push(32'h40000033);
        chk("lit_sub", {d_if.inst_type, d_if.alu_op}, {4'd1, 4'b1000});
        push(32'h40005013);
        chk("lit_srai", {d_if.inst_type, d_if.alu_op, d_if.illegal}, {4'd2, 4'b1101, 1'b0});
        push(32'h40001033);
        push(32'h40001013);
        push(32'h00002067);
        push(32'h00002063);
        push(32'h00000092);
        push(32'h800000B7);
        push(32'h00001003);
        push(32'h00004003);
        chk("lit_lbu", {d_if.inst_type, d_if.mem_size, d_if.is_mem_sign}, {4'd8, 2'd0, 1'b0});
        push(32'h0000000F);
        push(32'h00003023);

        // stores
        push(32'h00000023);
        chk("lit_sb", {d_if.mem_wbmask, d_if.mem_size}, {4'b0001, 2'd0});
        push(32'h00001023);
        chk("lit_sh", {d_if.mem_wbmask, d_if.mem_size}, {4'b0011, 2'd1});
        push(32'hFE502E23);
        chk("lit_sw", {d_if.mem_wbmask, d_if.mem_size, d_if.imm}, {4'b1111, 2'd2, 32'hFFFFFFFC});

        // RV32E instance
        push_e(32'h01000893);
        chk("lit_e_x17", {e_if.out_valid, e_if.illegal, e_if.inst_type}, {1'b1, 1'b1, 4'd0});
        push_e(32'h00500093);
        chk("lit_e_x1", {e_if.out_valid, e_if.illegal, e_if.inst_type}, {1'b1, 1'b0, 4'd2});

        // back-pressure: 4 addi while execute stalls for 3 edges
        @(posedge clock); #1;
        d_if.out_ready = 0;
        base = pc_c;
        p0 = pops;
        fork
            begin
                for (int k = 0; k < 4; k++) push(32'h00100093 + (32'(k) << 20));
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                chk("lit_hold", {d_if.in_ready, d_if.out_valid, d_if.imm, d_if.out_pc},
                    {1'b0, 1'b1, 32'd1, base});
                d_if.out_ready = 1;
            end
        join
        repeat (3) @(posedge clock);
        #1;
        chk("lit_bp_count", 32'(pops - p0), 4);

        // reset while a bundle is held
        d_if.out_ready = 0;
        push(32'h00700093);
        reset = 0;
        @(posedge clock); #1;
        reset = 1;
        chk("lit_rst_mid", {d_if.out_valid, d_if.imm}, 0);
        d_if.out_ready = 1;

        // halt
        push(32'h00000073);
        chk("lit_ecall", {d_if.inst_type, d_if.in_ready, d_if.halted}, {4'd12, 1'b0, 1'b0});
        d_if.in_valid = 1;
        d_if.in_inst  = 32'h00500093;
        d_if.in_pc    = pc_c;
        @(posedge clock); #1;
        chk("lit_halt", {d_if.halted, d_if.out_valid, d_if.in_ready}, {1'b1, 1'b0, 1'b0});
        repeat (5) @(posedge clock);
        #1;
        chk("lit_halt_hold", {d_if.halted, d_if.out_valid, d_if.in_ready}, {1'b1, 1'b0, 1'b0});
        d_if.in_valid = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
        chk("lit_unhalt", {d_if.halted, d_if.in_ready}, {1'b0, 1'b1});
        push(32'h00500093);
        chk("lit_run", {d_if.out_valid, d_if.inst_type}, {1'b1, 4'd2});
        repeat (3) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
